// File: rtl/irq_sequencer.sv
// irq_sequencer
//   Takes over the register file and data-memory port from the execute FSM
//   to run interrupt entry (push PC, push SR, clear SR, fetch vector, load PC)
//   and RETI (pop SR, pop PC). The execute FSM yields both resources while
//   busy=1.
//
// Ports
//   clk, srst       clock (rising edge); asynchronous active-high reset
//   irq[NIRQ]       level-sensitive requests, index 0 has highest priority
//   boundary        instruction boundary; sequences may only start here
//   reti            one-cycle strobe from the RETI decoder
//   flags           current SR (bit 3 = GIE)
//   busy            sequence in progress
//   irq_ack         one-hot pulse in the cycle PC is loaded from the vector
//   regno, store, data_in, As, bytemode, post_inc, sp_dec, reg_value
//                   register file control and read-back
//   mem_addr, mem_wdata, mem_we, mem_re, mem_rdata, mem_ready
//                   data-memory port; mem_ready completes the access
module irq_sequencer #(
    parameter int          NIRQ     = 8,
    parameter logic [15:0] VEC_BASE = 16'hFFE0
) (
    input  logic            clk,
    input  logic            srst,
    input  logic [NIRQ-1:0] irq,
    input  logic            boundary,
    input  logic            reti,
    input  logic [15:0]     flags,
    output logic            busy,
    output logic [NIRQ-1:0] irq_ack,
    output logic [3:0]      regno,
    output logic            store,
    output logic [15:0]     data_in,
    output logic [1:0]      As,
    output logic            bytemode,
    output logic            post_inc,
    output logic            sp_dec,
    input  logic [15:0]     reg_value,
    output logic [15:0]     mem_addr,
    output logic [15:0]     mem_wdata,
    output logic            mem_we,
    output logic            mem_re,
    input  logic [15:0]     mem_rdata,
    input  logic            mem_ready
);

    localparam int IW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

    localparam logic [3:0] REG_PC = 4'd0;
    localparam logic [3:0] REG_SP = 4'd1;
    localparam logic [3:0] REG_SR = 4'd2;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_RD_PC   = 4'd1;
    localparam logic [3:0] S_PUSH_PC = 4'd2;
    localparam logic [3:0] S_RD_SR   = 4'd3;
    localparam logic [3:0] S_PUSH_SR = 4'd4;
    localparam logic [3:0] S_CLR_SR  = 4'd5;
    localparam logic [3:0] S_RD_VEC  = 4'd6;
    localparam logic [3:0] S_LD_PC   = 4'd7;
    localparam logic [3:0] S_POP_SR  = 4'd8;
    localparam logic [3:0] S_INC1    = 4'd9;
    localparam logic [3:0] S_WR_SR   = 4'd10;
    localparam logic [3:0] S_POP_PC  = 4'd11;
    localparam logic [3:0] S_INC2    = 4'd12;
    localparam logic [3:0] S_WR_PC   = 4'd13;

    logic [3:0]    state_reg;
    logic [3:0]    state_next;
    logic [15:0]   pc_q;
    logic [15:0]   sr_q;
    logic [15:0]   vec_q;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] irq_idx;
    logic          start_entry;
    logic [15:0]   vec_addr;

    // Lowest set index wins: scan from the top so the last hit is the lowest.
    always_comb begin
        irq_idx = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (irq[i]) irq_idx = IW'(i);
        end
    end

    assign start_entry = boundary & flags[3] & (|irq);
    assign vec_addr    = VEC_BASE + 16'({idx_q, 1'b0});

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                // Entry takes precedence; a coincident reti is dropped.
                if (start_entry)  state_next = S_RD_PC;
                else if (reti)    state_next = S_POP_SR;
            end
            S_RD_PC:   state_next = S_PUSH_PC;
            S_PUSH_PC: if (mem_ready) state_next = S_RD_SR;
            S_RD_SR:   state_next = S_PUSH_SR;
            S_PUSH_SR: if (mem_ready) state_next = S_CLR_SR;
            S_CLR_SR:  state_next = S_RD_VEC;
            S_RD_VEC:  if (mem_ready) state_next = S_LD_PC;
            S_LD_PC:   state_next = S_IDLE;
            S_POP_SR:  if (mem_ready) state_next = S_INC1;
            S_INC1:    state_next = S_WR_SR;
            S_WR_SR:   state_next = S_POP_PC;
            S_POP_PC:  if (mem_ready) state_next = S_INC2;
            S_INC2:    state_next = S_WR_PC;
            S_WR_PC:   state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state_reg <= S_IDLE;
            pc_q      <= '0;
            sr_q      <= '0;
            vec_q     <= '0;
            idx_q     <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE:   if (start_entry) idx_q <= irq_idx;
                S_RD_PC:  pc_q <= reg_value;
                S_RD_SR:  sr_q <= reg_value;
                S_RD_VEC: if (mem_ready) vec_q <= mem_rdata;
                S_POP_SR: if (mem_ready) sr_q <= mem_rdata;
                S_POP_PC: if (mem_ready) pc_q <= mem_rdata;
                default: ;
            endcase
        end
    end

    // Outputs are a pure decode of state, so an asynchronous reset forces
    // them all to zero immediately.
    always_comb begin
        busy      = (state_reg != S_IDLE);
        regno     = REG_PC;
        store     = 1'b0;
        data_in   = '0;
        post_inc  = 1'b0;
        sp_dec    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        case (state_reg)
            S_RD_PC: regno = REG_PC;
            S_PUSH_PC, S_PUSH_SR: begin
                // sp_dec stays high through wait states; the register file
                // decrements once per rising edge of sp_dec, and reg_value
                // already reflects the decremented SP.
                regno     = REG_SP;
                sp_dec    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = reg_value;
                mem_wdata = (state_reg == S_PUSH_PC) ? pc_q : sr_q;
            end
            S_RD_SR: regno = REG_SR;
            S_CLR_SR: begin
                regno = REG_SR;
                store = 1'b1;
            end
            S_RD_VEC: begin
                mem_re   = 1'b1;
                mem_addr = vec_addr;
            end
            S_LD_PC: begin
                regno   = REG_PC;
                store   = 1'b1;
                data_in = vec_q;
            end
            S_POP_SR, S_POP_PC: begin
                regno    = REG_SP;
                mem_re   = 1'b1;
                mem_addr = reg_value;
            end
            S_INC1, S_INC2: begin
                regno    = REG_SP;
                post_inc = 1'b1;
            end
            S_WR_SR: begin
                regno   = REG_SR;
                store   = 1'b1;
                data_in = sr_q;
            end
            S_WR_PC: begin
                regno   = REG_PC;
                store   = 1'b1;
                data_in = pc_q;
            end
            default: ;
        endcase
    end

    assign As       = 2'b00;
    assign bytemode = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < NIRQ; gi++) begin : g_ack
            assign irq_ack[gi] = (state_reg == S_LD_PC) && (idx_q == IW'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_irq_sequencer.sv
// tb_irq_sequencer
//   Drives irq_sequencer against a behavioural register file (PC=r0, SP=r1,
//   SR=r2) and a word memory with programmable wait states. Stimulus pushes
//   expected events (memory writes, irq_ack pulses, end-of-sequence register
//   snapshots) into a queue; a monitor pops and compares them as the DUT
//   produces them.
module tb_irq_sequencer;

    localparam int KW = 0;  // memory write: a=addr b=data
    localparam int KA = 1;  // irq_ack:      a=ack
    localparam int KE = 2;  // sequence end: a=PC b=SP c=SR n=busy cycles m=post_inc cycles

    typedef struct {
        int          kind;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        int          n;
        int          m;
    } ev_t;

    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic [7:0]  irq = '0;
    logic        boundary = 1'b0;
    logic        reti = 1'b0;
    logic [15:0] flags;
    logic        busy;
    logic [7:0]  irq_ack;
    logic [3:0]  regno;
    logic        store;
    logic [15:0] data_in;
    logic [1:0]  As;
    logic        bytemode;
    logic        post_inc;
    logic        sp_dec;
    logic [15:0] reg_value;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_rdata;
    logic        mem_ready;

    irq_sequencer #(.NIRQ(8), .VEC_BASE(16'hFFE0)) dut (
        .clk(clk), .srst(srst), .irq(irq), .boundary(boundary), .reti(reti),
        .flags(flags), .busy(busy), .irq_ack(irq_ack), .regno(regno),
        .store(store), .data_in(data_in), .As(As), .bytemode(bytemode),
        .post_inc(post_inc), .sp_dec(sp_dec), .reg_value(reg_value),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    ev_t exp_q[$];

    // ---------------- register file model ----------------
    logic [15:0] rf [0:15];
    logic        dec_done = 1'b0;
    logic        do_preset = 1'b0;
    logic [15:0] pre_pc, pre_sp, pre_sr;

    always @(posedge clk) begin
        if (do_preset) begin
            rf[0] <= pre_pc;
            rf[1] <= pre_sp;
            rf[2] <= pre_sr;
        end else begin
            if (store)               rf[regno] <= data_in;
            if (post_inc)            rf[regno] <= rf[regno] + 16'd2;
            if (sp_dec && !dec_done) rf[1]     <= rf[1] - 16'd2;
        end
        dec_done <= sp_dec;
    end

    assign reg_value = (regno == 4'd1 && sp_dec && !dec_done) ? rf[1] - 16'd2 : rf[regno];
    assign flags     = rf[2];

    // ---------------- memory model ----------------
    logic [15:0] mem  [0:32767];
    logic [15:0] vrom [0:15];
    int          wait_cfg = 0;
    int          wcnt = 0;

    always @(posedge clk) begin
        if (mem_we && mem_ready) mem[mem_addr[15:1]] <= mem_wdata;
        if ((mem_we || mem_re) && !mem_ready) wcnt <= wcnt + 1;
        else                                  wcnt <= 0;
    end

    assign mem_ready = (mem_we || mem_re) && (wcnt == wait_cfg);
    assign mem_rdata = (mem_addr[15:5] == 11'h7FF) ? vrom[mem_addr[4:1]] : mem[mem_addr[15:1]];

    logic [68:0] all_outs;
    assign all_outs = {busy, irq_ack, regno, store, data_in, As, bytemode, post_inc,
                       sp_dec, mem_addr, mem_wdata, mem_we, mem_re};

    // ---------------- scoreboard helpers ----------------
    task automatic exp_write(input logic [15:0] a, input logic [15:0] d);
        ev_t e;
        e = '{kind: KW, a: a, b: d, c: 16'h0, n: 0, m: 0};
        exp_q.push_back(e);
    endtask

    task automatic exp_ack(input logic [15:0] a);
        ev_t e;
        e = '{kind: KA, a: a, b: 16'h0, c: 16'h0, n: 0, m: 0};
        exp_q.push_back(e);
    endtask

    task automatic exp_end(input logic [15:0] pc, input logic [15:0] sp,
                           input logic [15:0] sr, input int n, input int m);
        ev_t e;
        e = '{kind: KE, a: pc, b: sp, c: sr, n: n, m: m};
        exp_q.push_back(e);
    endtask

    task automatic cmp16(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic cmp_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic take(input int kind, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input int n, input int m);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d a=%h b=%h, expected none", kind, a, b);
        end else begin
            e = exp_q.pop_front();
            cmp_int("event_kind", kind, e.kind);
            if (kind == e.kind) begin
                case (kind)
                    KW: begin
                        cmp16("write_addr", a, e.a);
                        cmp16("write_data", b, e.b);
                    end
                    KA: cmp16("irq_ack", a, e.a);
                    default: begin
                        cmp16("end_pc", a, e.a);
                        cmp16("end_sp", b, e.b);
                        cmp16("end_sr", c, e.c);
                        cmp_int("busy_cycles", n, e.n);
                        cmp_int("post_inc_cycles", m, e.m);
                    end
                endcase
            end
            $display("txn kind=%0d a=%h b=%h c=%h n=%0d m=%0d", kind, a, b, c, n, m);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic        prev_busy;
        logic        was_wait;
        logic [15:0] held_addr, held_wdata;
        int          bcnt, pcnt;
        prev_busy = 1'b0;
        was_wait  = 1'b0;
        held_addr = '0;
        held_wdata = '0;
        bcnt = 0;
        pcnt = 0;
        forever begin
            @(negedge clk);
            if (srst) begin
                prev_busy = 1'b0;
                was_wait  = 1'b0;
                bcnt = 0;
                pcnt = 0;
            end else begin
                if (store && post_inc) begin
                    checks++; errors++;
                    $display("FAIL store_and_post_inc: got both high, required exclusive");
                end
                if (mem_we && mem_re) begin
                    checks++; errors++;
                    $display("FAIL we_and_re: got both high, required exclusive");
                end
                if (was_wait) begin
                    cmp16("wait_addr_stable", mem_addr, held_addr);
                    cmp16("wait_wdata_stable", mem_wdata, held_wdata);
                end
                was_wait   = (mem_we || mem_re) && !mem_ready;
                held_addr  = mem_addr;
                held_wdata = mem_wdata;
                if (busy) begin
                    bcnt++;
                    if (post_inc) pcnt++;
                end
                if (mem_we && mem_ready) take(KW, mem_addr, mem_wdata, 16'h0, 0, 0);
                if (irq_ack != 8'h00)    take(KA, {8'h00, irq_ack}, 16'h0, 16'h0, 0, 0);
                if (!busy && prev_busy) begin
                    take(KE, rf[0], rf[1], rf[2], bcnt, pcnt);
                    bcnt = 0;
                    pcnt = 0;
                end
                prev_busy = busy;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_regs(input logic [15:0] pc, input logic [15:0] sp, input logic [15:0] sr);
        @(posedge clk); #1;
        pre_pc = pc; pre_sp = sp; pre_sr = sr;
        do_preset = 1'b1;
        @(posedge clk); #1;
        do_preset = 1'b0;
    endtask

    task automatic start(input logic [7:0] irq_v, input logic bnd, input logic rt);
        @(posedge clk); #1;
        irq = irq_v; boundary = bnd; reti = rt;
        @(posedge clk); #1;
        irq = '0; boundary = 1'b0; reti = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 300) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (exp_q.size() != 0 || busy) begin
            errors++;
            $display("FAIL %s_timeout: got %0d events pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        for (int i = 0; i < 16; i++) vrom[i] = 16'h0;
        vrom[0] = 16'h5555;
        vrom[1] = 16'h7777;
        vrom[2] = 16'hF000;
        vrom[7] = 16'hABCD;
        pre_pc = '0; pre_sp = '0; pre_sr = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", all_outs);
        end
        #1 srst = 1'b0;
        set_regs(16'hC010, 16'h0400, 16'h0008);
        @(negedge clk);
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL idle_outputs: got %h expected 0", all_outs);
        end

        // 1: entry, irq 0x24 -> index 2, vector FFE4
        wait_cfg = 0;
        exp_write(16'h03FE, 16'hC010);
        exp_write(16'h03FC, 16'h0008);
        exp_ack(16'h0004);
        exp_end(16'hF000, 16'h03FC, 16'h0000, 7, 0);
        start(8'h24, 1'b1, 1'b0);
        wait_drain("entry1");

        // 2: GIE clear (SR=0 after entry) -> nothing may start
        @(posedge clk); #1;
        irq = 8'hFF; boundary = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (busy || store || sp_dec || post_inc || mem_we || mem_re) begin
                errors++;
                $display("FAIL gie_masked: got busy=%b strobes=%b%b%b%b%b expected all 0",
                         busy, store, sp_dec, post_inc, mem_we, mem_re);
            end
        end
        #1 irq = '0; boundary = 1'b0;

        // 3: RETI restores the frame pushed by test 1
        exp_end(16'hC010, 16'h0400, 16'h0008, 6, 2);
        start(8'h00, 1'b0, 1'b1);
        wait_drain("reti");

        // 4: three wait cycles per access, irq 7 -> vector FFEE
        set_regs(16'h1234, 16'h0200, 16'h0008);
        wait_cfg = 3;
        exp_write(16'h01FE, 16'h1234);
        exp_write(16'h01FC, 16'h0008);
        exp_ack(16'h0080);
        exp_end(16'hABCD, 16'h01FC, 16'h0000, 16, 0);
        start(8'h80, 1'b1, 1'b0);
        wait_drain("entry_wait");

        // 5: entry and reti together -> entry only
        set_regs(16'h2000, 16'h01FC, 16'h0008);
        wait_cfg = 0;
        exp_write(16'h01FA, 16'h2000);
        exp_write(16'h01F8, 16'h0008);
        exp_ack(16'h0001);
        exp_end(16'h5555, 16'h01F8, 16'h0000, 7, 0);
        start(8'h01, 1'b1, 1'b1);
        wait_drain("entry_vs_reti");
        repeat (4) @(negedge clk);
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL reti_dropped: got busy=1 expected 0");
        end

        // 6: reset during PUSH_SR, then a clean entry
        set_regs(16'h3000, 16'h0300, 16'h0008);
        wait_cfg = 3;
        exp_write(16'h02FE, 16'h3000);
        start(8'h02, 1'b1, 1'b0);
        k = 0;
        while (!(mem_we && mem_wdata == 16'h0008) && k < 100) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (!(mem_we && mem_wdata == 16'h0008)) begin
            errors++;
            $display("FAIL reach_push_sr: got mem_we=%b wdata=%h expected 1/0008", mem_we, mem_wdata);
        end
        #1 srst = 1'b1;
        #1;
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs: got %h expected 0", all_outs);
        end
        cmp_int("pending_at_reset", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        #1 srst = 1'b0;
        wait_cfg = 0;
        set_regs(16'h3000, 16'h0300, 16'h0008);
        exp_write(16'h02FE, 16'h3000);
        exp_write(16'h02FC, 16'h0008);
        exp_ack(16'h0002);
        exp_end(16'h7777, 16'h02FC, 16'h0000, 7, 0);
        start(8'h02, 1'b1, 1'b0);
        wait_drain("entry_after_reset");

        repeat (3) @(negedge clk);
        cmp_int("leftover_events", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
